// File: rtl/cache_pkg.sv
// Shared types, geometry and address helpers for the instruction-cache miss path.
package cache_pkg;

    localparam int NUM_THREADS    = 4;
    localparam int THR_W          = $clog2(NUM_THREADS);
    localparam int NUM_SET        = 4;
    localparam int NUM_SET_W      = $clog2(NUM_SET);
    localparam int WAYS_PER_SET   = 4;
    localparam int WAYS_PER_SET_W = $clog2(WAYS_PER_SET);
    localparam int ADDR_W         = 32;
    localparam int LINE_W         = 128;
    localparam int OFFSET_W       = $clog2(LINE_W / 8);
    localparam int TAG_W          = ADDR_W - NUM_SET_W - OFFSET_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PEND     = 2'd1,
        WAIT_RSP = 2'd2,
        FILL     = 2'd3
    } miss_state_t;

    typedef struct packed {
        logic [NUM_SET_W-1:0]      set_idx;
        logic [WAYS_PER_SET_W-1:0] way;
        logic [TAG_W-1:0]          tag;
        logic [THR_W-1:0]          thread;
        logic [LINE_W-1:0]         data;
    } fill_entry_t;

    function automatic logic [NUM_SET_W-1:0] addr_set(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: NUM_SET_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant starting at a pointer that moves
// past the winner only when the grant is consumed (i_advance).
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx
);

    logic [IDX_W-1:0] r_ptr;
    int               w_idx;

    // Scan from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (i_req[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = IDX_W'(w_idx);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_advance && (|i_req)) begin
            if (int'(o_grant_idx) == NUM_REQ - 1) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= o_grant_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/cache_miss_scheduler.sv
// Per-core I-cache miss controller: one outstanding miss per thread, a shared
// round-robin memory request port, and a victim-lookup -> fill/LRU-update pipeline.
module cache_miss_scheduler
    import cache_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_THREADS-1:0]        miss_req,
    input  logic [NUM_THREADS*ADDR_W-1:0] miss_addr,
    output logic [NUM_THREADS-1:0]        miss_ready,
    output logic [NUM_THREADS-1:0]        fill_done,
    output logic                          mem_req_valid,
    output logic [ADDR_W-1:0]             mem_req_addr,
    output logic [THR_W-1:0]              mem_req_thread,
    input  logic                          mem_req_ready,
    input  logic                          mem_rsp_valid,
    input  logic [THR_W-1:0]              mem_rsp_thread,
    input  logic [LINE_W-1:0]             mem_rsp_data,
    output logic                          victim_req,
    output logic [NUM_SET_W-1:0]          victim_set,
    output logic [THR_W-1:0]              victim_thread,
    input  logic [WAYS_PER_SET_W-1:0]     victim_way,
    output logic                          fill_valid,
    output logic [NUM_SET_W-1:0]          fill_set,
    output logic [WAYS_PER_SET_W-1:0]     fill_way,
    output logic [TAG_W-1:0]              fill_tag,
    output logic [LINE_W-1:0]             fill_data,
    output logic                          update_req_mt,
    output logic [NUM_SET_W-1:0]          update_set_mt,
    output logic [WAYS_PER_SET_W-1:0]     update_way_mt,
    output logic [THR_W-1:0]              update_thread_mt,
    output logic                          rsp_err,
    output miss_state_t [NUM_THREADS-1:0] dbg_state
);

    miss_state_t [NUM_THREADS-1:0] r_state;
    logic [ADDR_W-1:0]             r_addr [NUM_THREADS];
    logic                          r_lock;
    logic [THR_W-1:0]              r_lock_idx;
    logic                          r_fill_valid;
    fill_entry_t                   r_fill;
    logic                          r_rsp_err;

    logic [NUM_THREADS-1:0]        w_pend;
    logic [NUM_THREADS-1:0]        w_arb_req;
    logic [NUM_THREADS-1:0]        w_grant;
    logic [THR_W-1:0]              w_grant_idx;
    logic                          w_hs;
    logic                          w_rsp_ok;
    logic [ADDR_W-1:0]             w_rsp_addr;

    always_comb begin
        w_pend     = '0;
        miss_ready = '0;
        fill_done  = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            w_pend[t]     = (r_state[t] == PEND);
            miss_ready[t] = (r_state[t] == IDLE);
            fill_done[t]  = (r_state[t] == FILL);
        end
    end

    // A stalled grant is pinned by presenting only that thread to the arbiter,
    // which also keeps the pointer update tied to the thread actually served.
    assign w_arb_req = r_lock ? (NUM_THREADS'(1) << r_lock_idx) : w_pend;

    rr_arbiter #(
        .NUM_REQ (NUM_THREADS)
    ) u_arb (
        .i_clk       (clock),
        .i_rst_n     (reset),
        .i_req       (w_arb_req),
        .i_advance   (w_hs),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign mem_req_valid  = |w_arb_req;
    assign w_hs           = mem_req_valid & mem_req_ready;
    assign mem_req_thread = w_grant_idx;
    assign mem_req_addr   = mem_req_valid ? line_addr(r_addr[w_grant_idx]) : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_hs) begin
            r_lock <= 1'b0;
        end else if (mem_req_valid) begin
            r_lock     <= 1'b1;
            r_lock_idx <= w_grant_idx;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                r_state[t] <= IDLE;
                r_addr[t]  <= '0;
            end
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                unique case (r_state[t])
                    IDLE: begin
                        if (miss_req[t]) begin
                            r_state[t] <= PEND;
                            r_addr[t]  <= miss_addr[t*ADDR_W +: ADDR_W];
                        end
                    end
                    PEND: begin
                        if (w_hs && w_grant[t]) begin
                            r_state[t] <= WAIT_RSP;
                        end
                    end
                    WAIT_RSP: begin
                        if (mem_rsp_valid && (mem_rsp_thread == THR_W'(t))) begin
                            r_state[t] <= FILL;
                        end
                    end
                    FILL: r_state[t] <= IDLE;
                    default: r_state[t] <= IDLE;
                endcase
            end
        end
    end

    assign dbg_state  = r_state;
    assign w_rsp_ok   = mem_rsp_valid && (r_state[mem_rsp_thread] == WAIT_RSP);
    assign w_rsp_addr = r_addr[mem_rsp_thread];

    assign victim_req    = w_rsp_ok;
    assign victim_set    = w_rsp_ok ? addr_set(w_rsp_addr) : '0;
    assign victim_thread = w_rsp_ok ? mem_rsp_thread : '0;

    // Single-stage fill register: overwritten every response cycle, so
    // back-to-back responses from different threads stream through.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fill_valid <= 1'b0;
            r_fill       <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_fill_valid <= w_rsp_ok;
            if (w_rsp_ok) begin
                r_fill <= '{set_idx: addr_set(w_rsp_addr),
                            way:     victim_way,
                            tag:     addr_tag(w_rsp_addr),
                            thread:  mem_rsp_thread,
                            data:    mem_rsp_data};
            end
            if (mem_rsp_valid && !w_rsp_ok) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

    assign fill_valid       = r_fill_valid;
    assign fill_set         = r_fill.set_idx;
    assign fill_way         = r_fill.way;
    assign fill_tag         = r_fill.tag;
    assign fill_data        = r_fill.data;
    assign update_req_mt    = r_fill_valid;
    assign update_set_mt    = r_fill.set_idx;
    assign update_way_mt    = r_fill.way;
    assign update_thread_mt = r_fill.thread;
    assign rsp_err          = r_rsp_err;

endmodule

// File: tb/tb_cache_miss_scheduler.sv
// Directed bench for cache_miss_scheduler: single miss, round-robin grants,
// backpressure lock, back-to-back fills, spurious responses and mid-flight reset.
module tb_cache_miss_scheduler;
    import cache_pkg::*;

    logic                          clock;
    logic                          reset;
    logic [NUM_THREADS-1:0]        miss_req;
    logic [NUM_THREADS*ADDR_W-1:0] miss_addr;
    logic [NUM_THREADS-1:0]        miss_ready;
    logic [NUM_THREADS-1:0]        fill_done;
    logic                          mem_req_valid;
    logic [ADDR_W-1:0]             mem_req_addr;
    logic [THR_W-1:0]              mem_req_thread;
    logic                          mem_req_ready;
    logic                          mem_rsp_valid;
    logic [THR_W-1:0]              mem_rsp_thread;
    logic [LINE_W-1:0]             mem_rsp_data;
    logic                          victim_req;
    logic [NUM_SET_W-1:0]          victim_set;
    logic [THR_W-1:0]              victim_thread;
    logic [WAYS_PER_SET_W-1:0]     victim_way;
    logic                          fill_valid;
    logic [NUM_SET_W-1:0]          fill_set;
    logic [WAYS_PER_SET_W-1:0]     fill_way;
    logic [TAG_W-1:0]              fill_tag;
    logic [LINE_W-1:0]             fill_data;
    logic                          update_req_mt;
    logic [NUM_SET_W-1:0]          update_set_mt;
    logic [WAYS_PER_SET_W-1:0]     update_way_mt;
    logic [THR_W-1:0]              update_thread_mt;
    logic                          rsp_err;
    miss_state_t [NUM_THREADS-1:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [ADDR_W-1:0] a_t [NUM_THREADS];

    cache_miss_scheduler dut (
        .clock            (clock),
        .reset            (reset),
        .miss_req         (miss_req),
        .miss_addr        (miss_addr),
        .miss_ready       (miss_ready),
        .fill_done        (fill_done),
        .mem_req_valid    (mem_req_valid),
        .mem_req_addr     (mem_req_addr),
        .mem_req_thread   (mem_req_thread),
        .mem_req_ready    (mem_req_ready),
        .mem_rsp_valid    (mem_rsp_valid),
        .mem_rsp_thread   (mem_rsp_thread),
        .mem_rsp_data     (mem_rsp_data),
        .victim_req       (victim_req),
        .victim_set       (victim_set),
        .victim_thread    (victim_thread),
        .victim_way       (victim_way),
        .fill_valid       (fill_valid),
        .fill_set         (fill_set),
        .fill_way         (fill_way),
        .fill_tag         (fill_tag),
        .fill_data        (fill_data),
        .update_req_mt    (update_req_mt),
        .update_set_mt    (update_set_mt),
        .update_way_mt    (update_way_mt),
        .update_thread_mt (update_thread_mt),
        .rsp_err          (rsp_err),
        .dbg_state        (dbg_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        tick();
        reset = 1'b1;
    endtask

    function automatic logic [127:0] tag_of(input logic [ADDR_W-1:0] a);
        return 128'(a[31:6]);
    endfunction

    function automatic logic [127:0] line_of(input logic [ADDR_W-1:0] a);
        return 128'({a[31:4], 4'h0});
    endfunction

    initial begin
        reset          = 1'b0;
        miss_req       = '0;
        miss_addr      = '0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_thread = '0;
        mem_rsp_data   = '0;
        victim_way     = '0;
        #2;
        chk("rst_miss_ready", 128'(miss_ready), 128'(4'hf));
        chk("rst_mem_req_valid", 128'(mem_req_valid), 128'(0));
        chk("rst_fill_valid", 128'(fill_valid), 128'(0));
        chk("rst_update_req", 128'(update_req_mt), 128'(0));
        chk("rst_victim_req", 128'(victim_req), 128'(0));
        chk("rst_fill_done", 128'(fill_done), 128'(0));
        chk("rst_rsp_err", 128'(rsp_err), 128'(0));
        tick();
        reset = 1'b1;

        // Single miss on thread 0.
        mem_req_ready      = 1'b1;
        miss_req           = 4'b0001;
        miss_addr[0 +: 32] = 32'h0000_1230;
        tick();
        miss_req = '0;
        #1;
        chk("t1_req_valid", 128'(mem_req_valid), 128'(1));
        chk("t1_req_addr", 128'(mem_req_addr), 128'(32'h0000_1230));
        chk("t1_req_thread", 128'(mem_req_thread), 128'(0));
        chk("t1_miss_ready_busy", 128'(miss_ready), 128'(4'b1110));
        tick();
        chk("t1_req_valid_after_hs", 128'(mem_req_valid), 128'(0));
        chk("t1_state_wait", 128'(dbg_state[0]), 128'(WAIT_RSP));
        tick();
        tick();
        mem_rsp_valid  = 1'b1;
        mem_rsp_thread = 2'd0;
        mem_rsp_data   = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        victim_way     = 2'd2;
        #1;
        chk("t1_victim_req", 128'(victim_req), 128'(1));
        chk("t1_victim_set", 128'(victim_set), 128'(3));
        chk("t1_victim_thread", 128'(victim_thread), 128'(0));
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("t1_fill_valid", 128'(fill_valid), 128'(1));
        chk("t1_update_req", 128'(update_req_mt), 128'(1));
        chk("t1_fill_set", 128'(fill_set), 128'(3));
        chk("t1_update_set", 128'(update_set_mt), 128'(3));
        chk("t1_fill_way", 128'(fill_way), 128'(2));
        chk("t1_update_way", 128'(update_way_mt), 128'(2));
        chk("t1_update_thread", 128'(update_thread_mt), 128'(0));
        chk("t1_fill_tag", 128'(fill_tag), 128'(26'h48));
        chk("t1_fill_data", fill_data, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
        chk("t1_fill_done", 128'(fill_done), 128'(4'b0001));
        chk("t1_not_ready_in_fill", 128'(miss_ready), 128'(4'b1110));
        tick();
        chk("t1_fill_valid_clear", 128'(fill_valid), 128'(0));
        chk("t1_fill_done_clear", 128'(fill_done), 128'(0));
        chk("t1_ready_back", 128'(miss_ready), 128'(4'hf));

        // Four threads miss together; pointer starts at 0 after reset.
        do_reset();
        a_t[0] = 32'h0000_0040;
        a_t[1] = 32'h0000_0150;
        a_t[2] = 32'h0000_0A2C;
        a_t[3] = 32'h0001_23F8;
        for (int t = 0; t < 4; t++) miss_addr[t*32 +: 32] = a_t[t];
        miss_req = 4'hf;
        tick();
        miss_req = '0;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk($sformatf("t2_grant%0d_valid", g), 128'(mem_req_valid), 128'(1));
            chk($sformatf("t2_grant%0d_thread", g), 128'(mem_req_thread), 128'(g));
            chk($sformatf("t2_grant%0d_addr", g), 128'(mem_req_addr), line_of(a_t[g]));
            tick();
        end
        chk("t2_all_waiting", 128'(miss_ready), 128'(0));

        // Back-to-back responses for threads 1 and 3.
        mem_rsp_valid  = 1'b1;
        mem_rsp_thread = 2'd1;
        mem_rsp_data   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        victim_way     = 2'd1;
        #1;
        chk("t4_victim_set_t1", 128'(victim_set), 128'(1));
        chk("t4_victim_thread_t1", 128'(victim_thread), 128'(1));
        tick();
        mem_rsp_thread = 2'd3;
        mem_rsp_data   = 128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000;
        victim_way     = 2'd3;
        #1;
        chk("t4_victim_set_t3", 128'(victim_set), 128'(3));
        chk("t4_victim_req_t3", 128'(victim_req), 128'(1));
        chk("t4_fill_valid_t1", 128'(fill_valid), 128'(1));
        chk("t4_fill_set_t1", 128'(fill_set), 128'(1));
        chk("t4_fill_way_t1", 128'(fill_way), 128'(1));
        chk("t4_fill_tag_t1", 128'(fill_tag), tag_of(a_t[1]));
        chk("t4_fill_data_t1", fill_data, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        chk("t4_fill_done_t1", 128'(fill_done), 128'(4'b0010));
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("t4_fill_valid_t3", 128'(fill_valid), 128'(1));
        chk("t4_fill_set_t3", 128'(fill_set), 128'(3));
        chk("t4_update_way_t3", 128'(update_way_mt), 128'(3));
        chk("t4_update_thread_t3", 128'(update_thread_mt), 128'(3));
        chk("t4_fill_tag_t3", 128'(fill_tag), tag_of(a_t[3]));
        chk("t4_fill_data_t3", fill_data, 128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000);
        chk("t4_fill_done_t3", 128'(fill_done), 128'(4'b1000));
        chk("t4_ready_t1_back", 128'(miss_ready), 128'(4'b0010));

        // Thread 1 re-misses and is served while thread 0 is still outstanding.
        miss_req            = 4'b0010;
        miss_addr[32 +: 32] = 32'h0000_0770;
        tick();
        miss_req = '0;
        #1;
        chk("t2_remiss_thread", 128'(mem_req_thread), 128'(1));
        chk("t2_remiss_addr", 128'(mem_req_addr), 128'(32'h0000_0770));
        tick();

        // Backpressure: thread 2 granted, thread 1 arrives while stalled.
        do_reset();
        mem_req_ready       = 1'b0;
        miss_req            = 4'b0100;
        miss_addr[64 +: 32] = a_t[2];
        tick();
        miss_req = '0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("t3_stall%0d_valid", i), 128'(mem_req_valid), 128'(1));
            chk($sformatf("t3_stall%0d_thread", i), 128'(mem_req_thread), 128'(2));
            chk($sformatf("t3_stall%0d_addr", i), 128'(mem_req_addr), line_of(a_t[2]));
            if (i == 0) begin
                miss_req            = 4'b0010;
                miss_addr[32 +: 32] = a_t[1];
            end
            tick();
            miss_req = '0;
        end
        mem_req_ready = 1'b1;
        #1;
        chk("t3_hs_thread", 128'(mem_req_thread), 128'(2));
        tick();
        chk("t3_next_thread", 128'(mem_req_thread), 128'(1));
        chk("t3_next_addr", 128'(mem_req_addr), line_of(a_t[1]));
        tick();
        chk("t3_idle_valid", 128'(mem_req_valid), 128'(0));

        // Complete thread 2, then send it a spurious response while IDLE.
        mem_rsp_valid  = 1'b1;
        mem_rsp_thread = 2'd2;
        mem_rsp_data   = 128'h5a5a;
        victim_way     = 2'd0;
        #1;
        chk("t5_good_victim_set", 128'(victim_set), 128'(2));
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("t5_good_fill_tag", 128'(fill_tag), tag_of(a_t[2]));
        chk("t5_good_fill_done", 128'(fill_done), 128'(4'b0100));
        tick();
        mem_rsp_valid  = 1'b1;
        mem_rsp_data   = 128'hdead;
        #1;
        chk("t5_spur_no_victim", 128'(victim_req), 128'(0));
        chk("t5_err_not_yet", 128'(rsp_err), 128'(0));
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("t5_spur_no_fill", 128'(fill_valid), 128'(0));
        chk("t5_spur_no_done", 128'(fill_done), 128'(0));
        chk("t5_err_set", 128'(rsp_err), 128'(1));
        tick();
        tick();
        tick();
        chk("t5_err_held", 128'(rsp_err), 128'(1));

        // Reset while threads 0 and 1 wait for responses.
        do_reset();
        chk("t6_err_cleared", 128'(rsp_err), 128'(0));
        miss_req = 4'b0011;
        tick();
        miss_req = '0;
        tick();
        tick();
        chk("t6_both_waiting", 128'(miss_ready), 128'(4'b1100));
        reset = 1'b0;
        #1;
        chk("t6_rst_ready", 128'(miss_ready), 128'(4'hf));
        chk("t6_rst_req_valid", 128'(mem_req_valid), 128'(0));
        tick();
        reset          = 1'b1;
        mem_rsp_valid  = 1'b1;
        mem_rsp_thread = 2'd0;
        #1;
        chk("t6_late_no_victim", 128'(victim_req), 128'(0));
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        chk("t6_late_err", 128'(rsp_err), 128'(1));
        chk("t6_late_no_fill", 128'(fill_valid), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
